// File: rtl/fifo_burst_scheduler_if.sv
// Bundle of source-FIFO, memory-command and write-stream signals for the burst scheduler.
// The master modport is the scheduler's view; slave is the FIFO/memory side.
interface fifo_burst_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] Q0;
  logic [DATA_WIDTH-1:0] Q1;
  logic                  EMPTY0;
  logic                  EMPTY1;
  logic                  ALM_EMPTY0;
  logic                  ALM_EMPTY1;
  logic                  DEQ0;
  logic                  DEQ1;
  logic [ADDR_WIDTH-1:0] BASE0;
  logic [ADDR_WIDTH-1:0] BASE1;
  logic                  CMD_VALID;
  logic                  CMD_READY;
  logic [ADDR_WIDTH-1:0] CMD_ADDR;
  logic                  CMD_CH;
  logic                  WR_VALID;
  logic                  WR_READY;
  logic [DATA_WIDTH-1:0] WR_DATA;
  logic                  WR_LAST;
  logic                  BUSY;

  modport master (
    input  Q0, Q1, EMPTY0, EMPTY1, ALM_EMPTY0, ALM_EMPTY1, BASE0, BASE1,
    input  CMD_READY, WR_READY,
    output DEQ0, DEQ1, CMD_VALID, CMD_ADDR, CMD_CH,
    output WR_VALID, WR_DATA, WR_LAST, BUSY
  );

  modport slave (
    output Q0, Q1, EMPTY0, EMPTY1, ALM_EMPTY0, ALM_EMPTY1, BASE0, BASE1,
    output CMD_READY, WR_READY,
    input  DEQ0, DEQ1, CMD_VALID, CMD_ADDR, CMD_CH,
    input  WR_VALID, WR_DATA, WR_LAST, BUSY
  );
endinterface

// File: rtl/fifo_burst_scheduler.sv
// Two-channel round-robin burst scheduler: drains a source FIFO into one command
// plus a bounded data burst, through a 2-entry skid buffer, one burst at a time.
module fifo_burst_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 24,
  parameter int MAX_BURST  = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  fifo_burst_scheduler_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] XFER = 2'd2;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  logic [1:0]            state;
  logic                  grant;
  logic                  last_grant;
  logic [ADDR_WIDTH-1:0] ptr0;
  logic [ADDR_WIDTH-1:0] ptr1;
  logic [CNT_W-1:0]      cnt;
  logic                  last_deq;
  logic                  vld_p1;
  logic                  last_p1;
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic [1:0]            buf_last;
  logic                  wr_idx;
  logic                  rd_idx;
  logic [1:0]            occ;

  logic                  empty_g;
  logic                  alm_g;
  logic [DATA_WIDTH-1:0] q_g;
  logic                  wr_fire;
  logic [1:0]            occ_after;
  logic                  deq;
  logic                  deq_last;
  logic                  head_last;
  logic                  pick;

  always_comb begin
    empty_g   = grant ? bus.EMPTY1 : bus.EMPTY0;
    alm_g     = grant ? bus.ALM_EMPTY1 : bus.ALM_EMPTY0;
    q_g       = grant ? bus.Q1 : bus.Q0;
    wr_fire   = (occ != 2'd0) && bus.WR_READY;
    head_last = buf_last[rd_idx];
    // Credit the word leaving this cycle so a full-rate stream never bubbles.
    occ_after = occ - {1'b0, wr_fire};
    deq       = (state == XFER) && !RST && !empty_g && (cnt < MAX_CNT) && !last_deq &&
                ((occ_after + {1'b0, vld_p1}) < 2'd2);
    deq_last  = (cnt == MAX_CNT - 1'b1) || alm_g;
    if (!bus.EMPTY0 && !bus.EMPTY1) pick = ~last_grant;
    else                            pick = bus.EMPTY0;
  end

  assign bus.DEQ0      = deq & ~grant;
  assign bus.DEQ1      = deq & grant;
  assign bus.CMD_VALID = (state == CMD);
  assign bus.CMD_ADDR  = grant ? ptr1 : ptr0;
  assign bus.CMD_CH    = grant;
  assign bus.WR_VALID  = (occ != 2'd0);
  assign bus.WR_DATA   = buf_data[rd_idx];
  assign bus.WR_LAST   = (occ != 2'd0) & head_last;
  assign bus.BUSY      = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      ptr0       <= bus.BASE0;
      ptr1       <= bus.BASE1;
      cnt        <= '0;
      last_deq   <= 1'b0;
      vld_p1     <= 1'b0;
      wr_idx     <= 1'b0;
      rd_idx     <= 1'b0;
      occ        <= 2'd0;
    end else begin
      // p0 -> p1: a dequeue issued now lands on Qn next cycle
      vld_p1 <= deq;
      occ    <= occ - {1'b0, wr_fire} + {1'b0, vld_p1};
      if (vld_p1)  wr_idx <= ~wr_idx;
      if (wr_fire) rd_idx <= ~rd_idx;
      case (state)
        IDLE: begin
          cnt      <= '0;
          last_deq <= 1'b0;
          if (!bus.EMPTY0 || !bus.EMPTY1) begin
            grant      <= pick;
            last_grant <= pick;
            state      <= CMD;
          end
        end
        CMD: if (bus.CMD_READY) state <= XFER;
        XFER: begin
          if (deq) begin
            cnt      <= cnt + 1'b1;
            last_deq <= deq_last;
          end
          if (wr_fire && head_last) begin
            state <= IDLE;
            if (grant) ptr1 <= ptr1 + ADDR_WIDTH'(cnt);
            else       ptr0 <= ptr0 + ADDR_WIDTH'(cnt);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // p1 -> buffer: capture the word now presented on Qn
  always_ff @(posedge CLK) begin
    if (deq) last_p1 <= deq_last;
    if (vld_p1) begin
      buf_data[wr_idx] <= q_g;
      buf_last[wr_idx] <= last_p1;
    end
  end
endmodule

// File: doc/fifo_burst_scheduler.md
FIFO_BURST_SCHEDULER -- requirements
Module: fifo_burst_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width of both source FIFOs and the write stream.
REQ-002 Parameter ADDR_WIDTH, default 24: word-address width of the memory command.
REQ-003 Parameter MAX_BURST, default 16, legal range 2..256: maximum words per burst.
REQ-004 CLK  in  1: single clock; every port is synchronous to it.
REQ-005 RST  in  1: synchronous, active-high reset.
REQ-006 Q0, Q1  in  DATA_WIDTH: source FIFO read data; the word at the head appears one cycle after head moves.
REQ-007 EMPTY0, EMPTY1  in  1: source FIFO empty flags, registered, updated the cycle after DEQ.
REQ-008 ALM_EMPTY0, ALM_EMPTY1  in  1: source FIFO holds at most 1 word.
REQ-009 DEQ0, DEQ1  out  1: dequeue strobes, one word per asserted cycle.
REQ-010 BASE0, BASE1  in  ADDR_WIDTH: channel start addresses, sampled while RST=1.
REQ-011 CMD_VALID  out  1; CMD_READY  in  1; CMD_ADDR  out  ADDR_WIDTH; CMD_CH  out  1: burst command handshake.
REQ-012 WR_VALID  out  1; WR_READY  in  1; WR_DATA  out  DATA_WIDTH; WR_LAST  out  1: burst data stream.
REQ-013 BUSY  out  1: state is not IDLE.

Function
REQ-014 States SHALL be IDLE, CMD and XFER, with one burst in flight at most.
REQ-015 IDLE: if either EMPTYn=0, grant SHALL be registered and state SHALL go to CMD next cycle; otherwise stay in IDLE.
REQ-016 Arbitration SHALL be round-robin at burst boundaries: with both non-empty, the channel not granted last wins; after reset, channel 0 wins.
REQ-017 CMD: CMD_VALID=1, with CMD_CH=grant and CMD_ADDR=ptr[grant], all held stable until CMD_READY=1; then go to XFER.
REQ-018 XFER: DEQn SHALL be asserted only when granted, EMPTYn=0, words dequeued < MAX_BURST, LAST not yet dequeued, and (buffer occupancy + in-flight reads) < 2.
REQ-019 Each dequeued word SHALL be captured from Qn on the cycle after its DEQn into a 2-entry output buffer, preserving order.
REQ-020 A word's LAST flag SHALL be set at DEQ time if it is word MAX_BURST of the burst, or if ALM_EMPTYn=1 in that cycle.
REQ-021 WR_VALID=1 whenever the buffer is non-empty; the head word SHALL transfer when WR_VALID & WR_READY, and WR_DATA/WR_LAST SHALL hold while WR_READY=0.
REQ-022 Full throughput: with WR_READY held 1 and the FIFO supplying data, one word per cycle after a 1-cycle fill latency.
REQ-023 On transfer of the LAST word, state SHALL return to IDLE and ptr[grant] SHALL be advanced by the burst word count, modulo 2^ADDR_WIDTH.
REQ-024 The next burst's CMD_VALID SHALL be asserted no earlier than 2 cycles after the LAST handshake (IDLE then CMD).
REQ-025 If EMPTYn rises in XFER before LAST is dequeued, DEQ SHALL stall; the burst SHALL resume when EMPTYn falls and SHALL NOT be abandoned.
REQ-026 Non-granted DEQ SHALL stay 0; DEQ0 and DEQ1 SHALL never be asserted together.

Reset
REQ-027 While RST=1: state=IDLE, DEQ0=DEQ1=0, CMD_VALID=0, WR_VALID=0, WR_LAST=0, BUSY=0, buffer cleared, last-grant=1 (so channel 0 wins first), ptr0=BASE0, ptr1=BASE1.
REQ-028 Reset asserted mid-burst SHALL discard undelivered dequeued words and SHALL take effect on the next CLK edge.

Verification
REQ-029 Ch0 holds 40 words, BASE0=0x100, CMD_READY=WR_READY=1 -> bursts at addresses 0x100, 0x110, 0x120 of lengths 16, 16, 8, with WR_LAST on words 16, 32 and 40 and data in order.
REQ-030 Both channels hold 32 words, BASE1=0x800 -> CMD_CH sequence 0,1,0,1 at addresses 0x000, 0x800, 0x010, 0x810.
REQ-031 WR_READY toggles with a pseudo-random pattern during a 16-word burst -> no word lost or duplicated, at most 2 words buffered, and WR_DATA held stable while stalled.
REQ-032 Ch1 has 3 words, then 5 more arrive 20 cycles later -> first burst length 3 with LAST on word 3; second burst at BASE1+3, length 5.
REQ-033 CMD_READY held 0 for 10 cycles -> CMD_VALID, CMD_ADDR and CMD_CH stable for those 10 cycles and no DEQ asserted.
REQ-034 RST pulsed on word 5 of a burst -> next cycle all outputs at reset values and ptr reloaded from BASE; the following burst starts at BASE on channel 0.
